// File: rtl/calcu_pkg.sv
// Constants and state encoding for the calculator mailbox handshake.
// The firmware build uses the same mailbox layout and flag values.
package calcu_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_A,
    WR_B,
    WR_OP,
    WR_FLAG,
    POLL,
    READ_RES,
    DONE,
    ABORT
  } calcu_state_e;

  localparam logic [31:0] CALCU_OPA_ADDR  = 32'h0000_0000;
  localparam logic [31:0] CALCU_OPB_ADDR  = 32'h0000_0004;
  localparam logic [31:0] CALCU_OPC_ADDR  = 32'h0000_0008;
  localparam logic [31:0] CALCU_FLAG_ADDR = 32'h0000_000C;
  localparam logic [31:0] CALCU_RES_ADDR  = 32'h0000_0010;
  localparam int          CALCU_TIMEOUT   = 1024;

  localparam logic [31:0] FLAG_GO  = 32'h0000_0001;
  localparam logic [31:0] FLAG_CLR = 32'h0000_0000;

  function automatic logic [31:0] opcode_word(input logic [3:0] op);
    return {28'b0, op};
  endfunction

endpackage

// File: rtl/calcu_poll_timer.sv
// Poll-cycle counter: cleared before polling, bumped on each busy poll,
// and reports expiry on the last permitted poll.
module calcu_poll_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

  logic [CW-1:0] count_q, count_d;

  // Saturate at TIMEOUT so the counter can never wrap back into range.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LAST);

endmodule

// File: rtl/calcu_host_sequencer.sv
// Host side of the calculator mailbox: writes operands, raises GO,
// polls until firmware clears it, then returns the result word.
module calcu_host_sequencer
  import calcu_pkg::*;
#(
  parameter logic [31:0] OPA_ADDR  = CALCU_OPA_ADDR,
  parameter logic [31:0] OPB_ADDR  = CALCU_OPB_ADDR,
  parameter logic [31:0] OPC_ADDR  = CALCU_OPC_ADDR,
  parameter logic [31:0] FLAG_ADDR = CALCU_FLAG_ADDR,
  parameter logic [31:0] RES_ADDR  = CALCU_RES_ADDR,
  parameter int          TIMEOUT   = CALCU_TIMEOUT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [3:0]  opcode,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [31:0] result,
  output logic [31:0] addressCalcu,
  output logic [31:0] EntradaCalcu,
  output logic        writeEnableCalcu,
  input  logic [31:0] resultadoCalcu
);

  calcu_state_e state_q, state_d;
  logic [31:0]  a_q, a_d;
  logic [31:0]  b_q, b_d;
  logic [3:0]   op_q, op_d;
  logic [31:0]  result_q, result_d;
  logic         err_q, err_d;
  logic         timerClear;
  logic         timerInc;
  logic         timerExpired;

  calcu_poll_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_poll_timer (
    .clk      (CLK),
    .rst      (RST),
    .clear_i  (timerClear),
    .inc_i    (timerInc),
    .expired_o(timerExpired)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    result_d   = result_q;
    err_d      = err_q;
    timerClear = 1'b0;
    timerInc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = operand_a;
          b_d     = operand_b;
          op_d    = opcode;
          err_d   = 1'b0;
          state_d = WR_A;
        end
      end
      WR_A:    state_d = WR_B;
      WR_B:    state_d = WR_OP;
      WR_OP:   state_d = WR_FLAG;
      WR_FLAG: begin
        timerClear = 1'b1;
        state_d    = POLL;
      end
      // The counter still advances on the aborting poll; it saturates.
      POLL: begin
        if (resultadoCalcu == FLAG_CLR) begin
          state_d = READ_RES;
        end else begin
          timerInc = 1'b1;
          if (timerExpired) begin
            state_d = ABORT;
          end
        end
      end
      READ_RES: begin
        result_d = resultadoCalcu;
        state_d  = DONE;
      end
      DONE:  state_d = IDLE;
      ABORT: begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Bus is a pure decode of registered state so start never reaches it.
  always_comb begin
    addressCalcu     = RES_ADDR;
    EntradaCalcu     = FLAG_CLR;
    writeEnableCalcu = 1'b0;
    unique case (state_q)
      WR_A: begin
        addressCalcu     = OPA_ADDR;
        EntradaCalcu     = a_q;
        writeEnableCalcu = 1'b1;
      end
      WR_B: begin
        addressCalcu     = OPB_ADDR;
        EntradaCalcu     = b_q;
        writeEnableCalcu = 1'b1;
      end
      WR_OP: begin
        addressCalcu     = OPC_ADDR;
        EntradaCalcu     = opcode_word(op_q);
        writeEnableCalcu = 1'b1;
      end
      WR_FLAG: begin
        addressCalcu     = FLAG_ADDR;
        EntradaCalcu     = FLAG_GO;
        writeEnableCalcu = 1'b1;
      end
      POLL:  addressCalcu = FLAG_ADDR;
      ABORT: begin
        addressCalcu     = FLAG_ADDR;
        EntradaCalcu     = FLAG_CLR;
        writeEnableCalcu = 1'b1;
      end
      default: addressCalcu = RES_ADDR;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign timeout_err = err_q;
  assign result      = result_q;

endmodule

// File: tb/tb_calcu_host_sequencer.sv
// Scoreboard bench for calcu_host_sequencer with a mailbox memory and
// a firmware model that answers after a chosen number of busy polls.
module tb_calcu_host_sequencer;

  localparam int TIMEOUT = 8;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [3:0]  opcode = '0;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic [31:0] result;
  logic [31:0] addressCalcu;
  logic [31:0] EntradaCalcu;
  logic        writeEnableCalcu;
  logic [31:0] resultadoCalcu;

  logic [31:0] mem [8];
  int          fwDelay = 0;
  int          fwCnt = 0;
  wr_t         expWrites[$];
  logic [31:0] expResults[$];
  logic [31:0] lastResult = '0;
  int          tests = 0;
  int          failures = 0;

  calcu_host_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .start           (start),
    .operand_a       (operand_a),
    .operand_b       (operand_b),
    .opcode          (opcode),
    .busy            (busy),
    .done            (done),
    .timeout_err     (timeout_err),
    .result          (result),
    .addressCalcu    (addressCalcu),
    .EntradaCalcu    (EntradaCalcu),
    .writeEnableCalcu(writeEnableCalcu),
    .resultadoCalcu  (resultadoCalcu)
  );

  always #5 CLK = ~CLK;

  assign resultadoCalcu = mem[addressCalcu[4:2]];

  function automatic logic [31:0] calc(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] op);
    case (op)
      32'd1:   return a + b;
      32'd2:   return a - b;
      32'd3:   return a & b;
      32'd4:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Firmware: a negative delay means it never answers the GO flag.
  always @(posedge CLK) begin
    if (RST) begin
      fwCnt <= 0;
    end else begin
      if (writeEnableCalcu) mem[addressCalcu[4:2]] <= EntradaCalcu;
      if (writeEnableCalcu && addressCalcu == 32'hC && EntradaCalcu == 32'h1) begin
        if (fwDelay == 0) begin
          mem[4] <= calc(mem[0], mem[1], mem[2]);
          mem[3] <= 32'h0;
          fwCnt  <= 0;
        end else begin
          fwCnt <= (fwDelay > 0) ? fwDelay : 0;
        end
      end else if (fwCnt > 0) begin
        fwCnt <= fwCnt - 1;
        if (fwCnt == 1) begin
          mem[4] <= calc(mem[0], mem[1], mem[2]);
          mem[3] <= 32'h0;
        end
      end
    end
  end

  // Monitor: every bus write and every done pulse is matched to the queues.
  always @(negedge CLK) begin
    if (!RST) begin
      if (writeEnableCalcu) begin
        if (expWrites.size() == 0) begin
          checkOutput("unexpected_write_addr", addressCalcu, 32'hFFFF_FFFF);
        end else begin
          wr_t w;
          w = expWrites.pop_front();
          checkOutput("write_addr", addressCalcu, w.addr);
          checkOutput("write_data", EntradaCalcu, w.data);
        end
      end
      if (done) begin
        if (expResults.size() == 0) begin
          checkOutput("unexpected_done", {31'b0, done}, 32'h0);
        end else begin
          checkOutput("done_result", result, expResults.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] op, input int delay, input bit midStart);
    int doneCycle;
    int busyLow;
    bit willTimeout;
    willTimeout = (delay < 0) || (delay >= TIMEOUT);
    doneCycle = 0;
    busyLow = 0;
    @(negedge CLK);
    fwDelay   = delay;
    start     = 1'b1;
    operand_a = a;
    operand_b = b;
    opcode    = op;
    @(posedge CLK);
    #1;
    start     = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
    opcode    = 4'($urandom);
    expWrites.push_back('{32'h0, a});
    expWrites.push_back('{32'h4, b});
    expWrites.push_back('{32'h8, {28'b0, op}});
    expWrites.push_back('{32'hC, 32'h1});
    if (willTimeout) begin
      expWrites.push_back('{32'hC, 32'h0});
    end else begin
      lastResult = calc(a, b, {28'b0, op});
      expResults.push_back(lastResult);
    end
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK);
      if (k == 1) checkOutput("err_cleared_on_start", {31'b0, timeout_err}, 32'h0);
      if (done && doneCycle == 0) doneCycle = k;
      if (midStart && k == 6) begin
        start     = 1'b1;
        operand_a = 32'd9;
      end
      if (midStart && k == 7) start = 1'b0;
      if (!busy) begin
        busyLow = k;
        break;
      end
    end
    if (willTimeout) begin
      checkOutput("timeout_busy_end", busyLow, 4 + TIMEOUT + 2);
      checkOutput("timeout_no_done", doneCycle, 0);
      checkOutput("timeout_err_set", {31'b0, timeout_err}, 32'h1);
      checkOutput("timeout_result_held", result, lastResult);
    end else begin
      checkOutput("done_latency", doneCycle, 7 + delay);
      checkOutput("busy_end", busyLow, 8 + delay);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    repeat (2) @(negedge CLK);
    checkOutput("rst_busy", {31'b0, busy}, 32'h0);
    checkOutput("rst_done", {31'b0, done}, 32'h0);
    checkOutput("rst_err", {31'b0, timeout_err}, 32'h0);
    checkOutput("rst_result", result, 32'h0);
    checkOutput("rst_addr", addressCalcu, 32'h10);
    checkOutput("rst_we", {31'b0, writeEnableCalcu}, 32'h0);
    checkOutput("rst_wdata", EntradaCalcu, 32'h0);
    RST = 1'b0;

    applyStimulus(32'd5, 32'd3, 4'd1, 3, 1'b0);
    applyStimulus(32'd2, 32'd4, 4'd2, 0, 1'b0);
    applyStimulus(32'hDEAD_BEEF, 32'h1234_5678, 4'd3, -1, 1'b0);
    applyStimulus($urandom, $urandom, 4'($urandom_range(1, 5)), 2, 1'b0);
    applyStimulus(32'd7, 32'd6, 4'd1, 4, 1'b1);
    applyStimulus($urandom, $urandom, 4'd5, TIMEOUT - 1, 1'b0);

    // Reset asserted while WR_B is on the bus.
    @(negedge CLK);
    start     = 1'b1;
    operand_a = 32'h1111_1111;
    operand_b = 32'h2222_2222;
    opcode    = 4'd4;
    @(posedge CLK);
    #1;
    start = 1'b0;
    expWrites.push_back('{32'h0, 32'h1111_1111});
    expWrites.push_back('{32'h4, 32'h2222_2222});
    expWrites.push_back('{32'h8, 32'h4});
    expWrites.push_back('{32'hC, 32'h1});
    repeat (2) @(negedge CLK);
    checkOutput("wrb_we", {31'b0, writeEnableCalcu}, 32'h1);
    checkOutput("wrb_addr", addressCalcu, 32'h4);
    #2 RST = 1'b1;
    #1;
    checkOutput("midrst_we", {31'b0, writeEnableCalcu}, 32'h0);
    checkOutput("midrst_addr", addressCalcu, 32'h10);
    checkOutput("midrst_busy", {31'b0, busy}, 32'h0);
    checkOutput("midrst_result", result, 32'h0);
    expWrites.delete();
    lastResult = '0;
    @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    checkOutput("midrst_idle", {31'b0, busy}, 32'h0);

    applyStimulus(32'd100, 32'd58, 4'd2, 1, 1'b0);
    for (int n = 0; n < 6; n++) begin
      applyStimulus($urandom, $urandom, 4'($urandom_range(1, 5)),
                    int'($urandom_range(0, 6)), 1'b0);
    end

    repeat (3) @(negedge CLK);
    checkOutput("write_queue_drained", expWrites.size(), 32'h0);
    checkOutput("result_queue_drained", expResults.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
